// File: rtl/jtag_ahb_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the JTAG debug AHB master.
// Only single-beat word transfers are ever issued, so HSIZE/HBURST are constants.
package jtag_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [7:0] WAIT_MAX      = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == WAIT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/jtag_ahb_master.sv
// Turns one debug request at a time into a single AHB-Lite word transfer and
// returns read data, error status and a saturating count of data-phase wait states.
module jtag_ahb_master
    import jtag_ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32   // only 32 is supported
) (
    input  logic                  HCLK,
    input  logic                  HRESET,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [7:0]            rsp_waits,

    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    state_e                  state_q;
    logic                    req_ready_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [ADDR_WIDTH-1:0]   haddr_q;
    logic [1:0]              htrans_q;
    logic                    hwrite_q;
    logic [DATA_WIDTH-1:0]   hwdata_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic [7:0]              rsp_waits_q;
    logic                    err_q;
    logic [7:0]              wait_q;

    logic                    err_d;
    logic [7:0]              wait_d;
    logic                    accept;

    // An HRESP seen in this data cycle counts even on the completing edge.
    assign err_d  = err_q | HRESP;
    assign wait_d = sat_inc(wait_q);
    assign accept = req_valid && req_ready_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            wdata_q     <= '0;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_waits_q <= '0;
            err_q       <= 1'b0;
            wait_q      <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        wdata_q     <= req_wdata;
                        if (req_addr[1:0] == 2'b00) begin
                            haddr_q  <= req_addr;
                            hwrite_q <= req_write;
                            htrans_q <= HTRANS_NONSEQ;
                            state_q  <= ST_ADDR;
                        end else begin
                            // Misaligned: answer immediately, never touch the bus.
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_waits_q <= '0;
                            state_q     <= ST_RESP;
                        end
                    end
                end

                ST_ADDR: begin
                    if (HREADY) begin
                        htrans_q <= HTRANS_IDLE;
                        hwdata_q <= hwrite_q ? wdata_q : '0;
                        state_q  <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    err_q <= err_d;
                    if (HREADY) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= (hwrite_q || err_d) ? '0 : HRDATA;
                        rsp_err_q   <= err_d;
                        rsp_waits_q <= wait_q;
                        state_q     <= ST_RESP;
                    end else begin
                        wait_q <= wait_d;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        wait_q      <= '0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_waits = rsp_waits_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;
    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;

endmodule

// File: tb/tb_jtag_ahb_master.sv
// Self-checking bench for jtag_ahb_master: directed scenarios plus randomized
// transfers compared against a transaction-level reference model.
module tb_jtag_ahb_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  rsp_waits;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int          acc_wait;
        int          latency;
        int          nonseq;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        unstable;
        logic        busy_ready;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  waits;
        logic        timeout;
    } obs_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [7:0]  waits;
        int          latency;
        int          nonseq;
    } exp_t;

    always #5 HCLK = ~HCLK;

    jtag_ahb_master dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_waits (rsp_waits),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Transaction-level expectation: what the debug side should see for one request.
    function automatic exp_t model(input logic wr, input logic [31:0] addr, input logic [31:0] rdata,
                                   input int aw, input int dw, input logic herr);
        exp_t e;
        bit   mis;
        mis       = (addr[1:0] != 2'b00);
        e.err     = mis || herr;
        e.rdata   = (wr || e.err) ? 32'h0 : rdata;
        e.waits   = mis ? 8'd0 : 8'((dw > 255) ? 255 : dw);
        e.latency = mis ? 1 : 3 + aw + dw;
        e.nonseq  = mis ? 0 : 1 + aw;
        return e;
    endfunction

    // Drives one request and plays an AHB slave with the given address/data wait counts.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int aw, input int dw,
                           input int rsp_delay, input logic herr, output obs_t o);
        bit first_ns, first_data, in_data, go_data;
        int awl, dwl;
        logic [31:0] scramble;
        o = '{default: 0};
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        while (req_ready !== 1'b1 && o.acc_wait < 10) begin
            tick();
            o.acc_wait++;
        end
        if (req_ready !== 1'b1) begin
            o.timeout = 1'b1;
            req_valid = 1'b0;
            return;
        end
        tick();
        req_valid = 1'b0;
        scramble  = $urandom;
        req_addr  = scramble;
        req_wdata = ~scramble;
        req_write = scramble[0];
        awl = aw; dwl = dw;
        in_data = 0; first_ns = 1; first_data = 1;
        o.timeout = 1'b1;
        for (int c = 0; c < aw + dw + 20; c++) begin
            HREADY = 1'b1;
            HRESP  = 1'b0;
            HRDATA = $urandom;
            if (rsp_valid === 1'b1) begin
                o.latency = c + 1;
                o.rdata   = rsp_rdata;
                o.err     = rsp_err;
                o.waits   = rsp_waits;
                o.timeout = 1'b0;
                for (int d = 0; d < rsp_delay; d++) begin
                    tick();
                    if (rsp_valid !== 1'b1 || rsp_rdata !== o.rdata || rsp_err !== o.err ||
                        rsp_waits !== o.waits || HTRANS !== 2'b00) o.unstable = 1'b1;
                end
                rsp_ready = 1'b1;
                tick();
                rsp_ready = 1'b0;
                break;
            end
            if (req_ready !== 1'b0) o.busy_ready = 1'b1;
            if (HSIZE !== 3'b010 || HBURST !== 3'b000) o.unstable = 1'b1;
            go_data = 0;
            if (HTRANS === 2'b10) begin
                if (in_data) o.unstable = 1'b1;
                if (first_ns) begin
                    o.addr = HADDR; o.wr = HWRITE; first_ns = 0;
                end else if (HADDR !== o.addr || HWRITE !== o.wr) begin
                    o.unstable = 1'b1;
                end
                o.nonseq++;
                if (awl > 0) begin HREADY = 1'b0; awl--; end
                else go_data = 1;
            end else if (HTRANS !== 2'b00) begin
                o.unstable = 1'b1;
            end else if (in_data) begin
                if (first_data) begin
                    o.wdata = HWDATA; first_data = 0;
                end else if (HWDATA !== o.wdata) begin
                    o.unstable = 1'b1;
                end
                HRESP = herr;
                if (dwl > 0) begin HREADY = 1'b0; dwl--; end
                else HRDATA = rdata;
            end
            tick();
            if (go_data) in_data = 1;
        end
        HREADY = 1'b1;
        HRESP  = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        tick();
        tick();
        vectors++;
        if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HWDATA !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_bus: got htrans=%b haddr=%h hwrite=%b hwdata=%h want all zero",
                     HTRANS, HADDR, HWRITE, HWDATA);
        end
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_waits !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_rsp: got valid=%b rdata=%h err=%b waits=%0d want all zero",
                     rsp_valid, rsp_rdata, rsp_err, rsp_waits);
        end
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_low: got %b want 0", req_ready);
        end
        HRESET = 1'b0;
        tick();
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready_release: got %b want 1", req_ready);
        end
    endtask

    task automatic test_write();
        obs_t o;
        run_txn(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h5555_AAAA, 0, 0, 0, 1'b0, o);
        vectors++;
        if (o.nonseq !== 1 || o.addr !== 32'h0000_1000 || o.wr !== 1'b1) begin
            miscompares++;
            $display("FAIL write_addr_phase: got nonseq=%0d addr=%h wr=%b want 1 00001000 1", o.nonseq, o.addr, o.wr);
        end
        vectors++;
        if (o.wdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL write_hwdata: got %h want deadbeef", o.wdata);
        end
        vectors++;
        if (o.err !== 1'b0 || o.waits !== 8'd0 || o.rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL write_rsp: got err=%b waits=%0d rdata=%h want 0 0 0", o.err, o.waits, o.rdata);
        end
        vectors++;
        if (o.latency !== 3 || o.timeout) begin
            miscompares++;
            $display("FAIL write_latency: got %0d (timeout=%b) want 3", o.latency, o.timeout);
        end
    endtask

    task automatic test_read_waits();
        obs_t o;
        run_txn(1'b0, 32'h0000_2004, 32'h0, 32'h1234_5678, 0, 3, 2, 1'b0, o);
        vectors++;
        if (o.rdata !== 32'h1234_5678 || o.waits !== 8'd3 || o.err !== 1'b0) begin
            miscompares++;
            $display("FAIL read_waits: got rdata=%h waits=%0d err=%b want 12345678 3 0", o.rdata, o.waits, o.err);
        end
        vectors++;
        if (o.unstable || o.busy_ready || o.latency !== 6) begin
            miscompares++;
            $display("FAIL read_waits_proto: got unstable=%b busy_ready=%b latency=%0d want 0 0 6",
                     o.unstable, o.busy_ready, o.latency);
        end
    endtask

    task automatic test_read_error();
        obs_t o;
        run_txn(1'b0, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 0, 1, 0, 1'b1, o);
        vectors++;
        if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.waits !== 8'd1) begin
            miscompares++;
            $display("FAIL read_error: got err=%b rdata=%h waits=%0d want 1 0 1", o.err, o.rdata, o.waits);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_txn(1'b1, 32'h0000_0002, 32'h1111_2222, 32'h0, 0, 0, 0, 1'b0, o);
        vectors++;
        if (o.nonseq !== 0 || o.latency !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0 || o.waits !== 8'd0) begin
            miscompares++;
            $display("FAIL misaligned: got nonseq=%0d latency=%0d err=%b rdata=%h waits=%0d want 0 1 1 0 0",
                     o.nonseq, o.latency, o.err, o.rdata, o.waits);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready%0d: got %b want 1", i, req_ready);
            end
            run_txn(1'b0, 32'h0000_0100 + 32'(i * 4), 32'h0, 32'hA000_0000 + 32'(i), 0, 0, 0, 1'b0, o);
            vectors++;
            if (o.acc_wait !== 0 || o.rdata !== 32'hA000_0000 + 32'(i) || o.latency !== 3) begin
                miscompares++;
                $display("FAIL b2b_txn%0d: got acc_wait=%0d rdata=%h latency=%0d want 0 %h 3",
                         i, o.acc_wait, o.rdata, o.latency, 32'hA000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_mid_data();
        bit spurious;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_4000; req_wdata = 32'h0;
        HREADY = 1'b1; HRESP = 1'b0;
        tick();
        req_valid = 1'b0;
        vectors++;
        if (HTRANS !== 2'b10) begin
            miscompares++;
            $display("FAIL midrst_addr: got htrans=%b want 10", HTRANS);
        end
        tick();
        HREADY = 1'b0;
        tick();
        tick();
        HRESET = 1'b1;
        tick();
        vectors++;
        if (HTRANS !== 2'b00 || rsp_valid !== 1'b0 || req_ready !== 1'b0 || HADDR !== 32'h0) begin
            miscompares++;
            $display("FAIL midrst_in_reset: got htrans=%b rsp_valid=%b req_ready=%b haddr=%h want 00 0 0 0",
                     HTRANS, rsp_valid, req_ready, HADDR);
        end
        HRESET = 1'b0;
        HREADY = 1'b1;
        tick();
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_release: got req_ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid);
        end
        spurious = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) spurious = 1;
        end
        vectors++;
        if (spurious) begin
            miscompares++;
            $display("FAIL midrst_quiet: got spurious activity=1 want 0");
        end
    endtask

    task automatic test_saturation();
        obs_t o;
        run_txn(1'b0, 32'h0000_5000, 32'h0, 32'h0BAD_CAFE, 0, 300, 0, 1'b0, o);
        vectors++;
        if (o.waits !== 8'd255 || o.rdata !== 32'h0BAD_CAFE || o.latency !== 303) begin
            miscompares++;
            $display("FAIL saturation: got waits=%0d rdata=%h latency=%0d want 255 0badcafe 303",
                     o.waits, o.rdata, o.latency);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic        wr, herr;
        logic [31:0] addr, wdata, rdata, r;
        int          aw, dw, rd;
        for (int i = 0; i < 40; i++) begin
            r     = $urandom;
            wr    = r[0];
            herr  = (r[7:4] < 4'd3);
            addr  = $urandom;
            if (r[11:10] != 2'b00) addr[1:0] = 2'b00;
            wdata = $urandom;
            rdata = $urandom;
            aw    = $urandom_range(0, 3);
            dw    = $urandom_range(0, 5);
            rd    = $urandom_range(0, 3);
            e     = model(wr, addr, rdata, aw, dw, herr);
            run_txn(wr, addr, wdata, rdata, aw, dw, rd, herr, o);
            vectors++;
            if (o.timeout || o.latency !== e.latency || o.nonseq !== e.nonseq) begin
                miscompares++;
                $display("FAIL rnd%0d_timing: got latency=%0d nonseq=%0d timeout=%b want %0d %0d 0",
                         i, o.latency, o.nonseq, o.timeout, e.latency, e.nonseq);
            end
            vectors++;
            if (o.err !== e.err || o.rdata !== e.rdata || o.waits !== e.waits) begin
                miscompares++;
                $display("FAIL rnd%0d_rsp: got err=%b rdata=%h waits=%0d want %b %h %0d",
                         i, o.err, o.rdata, o.waits, e.err, e.rdata, e.waits);
            end
            vectors++;
            if (o.unstable || o.busy_ready) begin
                miscompares++;
                $display("FAIL rnd%0d_proto: got unstable=%b busy_ready=%b want 0 0", i, o.unstable, o.busy_ready);
            end
            if (e.nonseq > 0) begin
                vectors++;
                if (o.addr !== addr || o.wr !== wr || (wr && o.wdata !== wdata)) begin
                    miscompares++;
                    $display("FAIL rnd%0d_bus: got addr=%h wr=%b wdata=%h want %h %b %h",
                             i, o.addr, o.wr, o.wdata, addr, wr, wdata);
                end
            end
        end
    endtask

    initial begin
        HRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        HRDATA    = 32'h0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        test_reset();
        test_write();
        test_read_waits();
        test_read_error();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_data();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #(500_000);
        $display("FAIL watchdog: got no completion after 50000 cycles want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
